// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler
// Runs the fillscreen (0), circle (1) and reuleaux (2) engines one after another and grants
// the single VGA plot port to whichever engine is running. A per-engine watchdog aborts an
// engine that holds its grant too long. Plots that fall off-screen are suppressed.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   start_i            run request (level, held until done_o)
//   en_mask_i          per-engine enable, latched when a run starts
//   done_o, busy_o     sequence finished / sequence in progress
//   cur_eng_o          granted engine index, 3 when none
//   timeout_err_o      sticky per-engine abort flags, cleared when a run starts
//   eng_start_o        one-hot start to the engines
//   eng_done_i         per-engine completion
//   eng_x/y/colour_i   per-engine plot coordinates and colour
//   eng_plot_i         per-engine plot strobe
//   vga_*_o            muxed and clipped plot port to the adapter
module vga_draw_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   parameter int unsigned SCREEN_W       = 160,
   parameter int unsigned SCREEN_H       = 120
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [2:0]      en_mask_i,
   output logic            done_o,
   output logic            busy_o,
   output logic [1:0]      cur_eng_o,
   output logic [2:0]      timeout_err_o,
   output logic [2:0]      eng_start_o,
   input  logic [2:0]      eng_done_i,
   input  logic [2:0][7:0] eng_x_i,
   input  logic [2:0][6:0] eng_y_i,
   input  logic [2:0][2:0] eng_colour_i,
   input  logic [2:0]      eng_plot_i,
   output logic [7:0]      vga_x_o,
   output logic [6:0]      vga_y_o,
   output logic [2:0]      vga_colour_o,
   output logic            vga_plot_o
);

   localparam int unsigned    WdW    = $clog2(TIMEOUT_CYCLES);
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]     NoEng  = 2'd3;

   typedef enum logic [2:0] {StIdle, StSelect, StRun, StGap, StDone} state_e;

   state_e         state_q;
   logic [1:0]     idx_q;
   logic [2:0]     mask_q;
   logic [1:0]     cur_eng_q;
   logic [2:0]     eng_start_q;
   logic           done_q;
   logic           busy_q;
   logic [2:0]     timeout_err_q;
   logic [WdW-1:0] wd_q;

   logic           sel_found;
   logic [1:0]     sel_idx;
   logic           done_hit;

   // Lowest enabled engine at or above idx_q; scanning downwards leaves the lowest one.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         if (mask_q[i] && (2'(i) >= idx_q)) begin
            sel_found = 1'b1;
            sel_idx   = 2'(i);
         end
      end
   end

   // eng_start_q is one-hot on the granted engine while running, so it masks foreign dones.
   assign done_hit = |(eng_done_i & eng_start_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= StIdle;
         idx_q         <= 2'd0;
         mask_q        <= 3'b000;
         cur_eng_q     <= NoEng;
         eng_start_q   <= 3'b000;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         timeout_err_q <= 3'b000;
         wd_q          <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  mask_q        <= en_mask_i;
                  idx_q         <= 2'd0;
                  timeout_err_q <= 3'b000;
                  busy_q        <= 1'b1;
                  state_q       <= StSelect;
               end
            end
            StSelect: begin
               if (sel_found) begin
                  cur_eng_q   <= sel_idx;
                  eng_start_q <= 3'b001 << sel_idx;
                  wd_q        <= '0;
                  state_q     <= StRun;
               end else begin
                  cur_eng_q <= NoEng;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StDone;
               end
            end
            StRun: begin
               wd_q <= wd_q + 1'b1;
               if (done_hit) begin
                  eng_start_q <= 3'b000;
                  state_q     <= StGap;
               end else if (wd_q == WdLast) begin
                  timeout_err_q <= timeout_err_q | eng_start_q;
                  eng_start_q   <= 3'b000;
                  state_q       <= StGap;
               end
            end
            StGap: begin
               // Start is already low here, so every engine sees it fall before the next one.
               wd_q <= '0;
               if (cur_eng_q == 2'd2) begin
                  cur_eng_q <= NoEng;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StDone;
               end else begin
                  idx_q   <= cur_eng_q + 2'd1;
                  state_q <= StSelect;
               end
            end
            StDone: begin
               if (!start_i) begin
                  done_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Plot mux: no added latency; only the granted engine in RUN may plot, and only on-screen.
   always_comb begin
      vga_x_o      = '0;
      vga_y_o      = '0;
      vga_colour_o = '0;
      vga_plot_o   = 1'b0;
      if (cur_eng_q != NoEng) begin
         vga_x_o      = eng_x_i[cur_eng_q];
         vga_y_o      = eng_y_i[cur_eng_q];
         vga_colour_o = eng_colour_i[cur_eng_q];
         vga_plot_o   = eng_plot_i[cur_eng_q] && (state_q == StRun) &&
                        (32'(eng_x_i[cur_eng_q]) < SCREEN_W) &&
                        (32'(eng_y_i[cur_eng_q]) < SCREEN_H);
      end
   end

   assign done_o        = done_q;
   assign busy_o        = busy_q;
   assign cur_eng_o     = cur_eng_q;
   assign timeout_err_o = timeout_err_q;
   assign eng_start_o   = eng_start_q;

endmodule

// File: doc/vga_draw_scheduler.md
Name: vga_draw_scheduler

Overview:
- Sequences the three drawing engines (0 = fillscreen, 1 = circle, 2 = reuleaux) in a fixed order.
- Grants the single VGA adapter plot port (160x120, 3-bit colour) to one engine at a time.
- Runs a per-engine watchdog and clips off-screen plots.
- Sits between the engines and vga_adapter in the task top level.

Parameters:
- TIMEOUT_CYCLES, 65536: maximum cycles an engine may hold its grant before it is aborted. Legal range 2 to 2^20.
- SCREEN_W, 160: plots with x >= SCREEN_W are suppressed.
- SCREEN_H, 120: plots with y >= SCREEN_H are suppressed.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- rst_n  in  1  asynchronous active-low reset (KEY[3] at top level).
- start  in  1  run request; level, held high until done.
- en_mask  in  3  bit i enables engine i; latched when leaving IDLE.
- done  out  1  whole sequence finished.
- busy  out  1  high from SELECT through GAP.
- cur_eng  out  2  index of the granted engine; 3 when none is granted.
- timeout_err  out  3  sticky; bit i set when engine i was aborted.
- eng_start  out  3  one-hot start to the engines.
- eng_done  in  3  done from each engine.
- eng_x  in  3x8  packed [2:0][7:0], per-engine x.
- eng_y  in  3x7  packed [2:0][6:0], per-engine y.
- eng_colour  in  3x3  packed [2:0][2:0], per-engine colour.
- eng_plot  in  3  per-engine plot strobe.
- vga_x  out  8  to vga_adapter.
- vga_y  out  7  to vga_adapter.
- vga_colour  out  3  to vga_adapter.
- vga_plot  out  1  to vga_adapter.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE, cur_eng = 3, eng_start = 0, done = 0, busy = 0, timeout_err = 0, watchdog = 0, latched mask = 0.
  - vga_plot = 0; vga_x, vga_y, vga_colour = 0.
- FSM states: IDLE, SELECT, RUN, GAP, DONE. Index register idx (2 bits).
- IDLE: at an edge where start = 1, latch en_mask, set idx = 0, go to SELECT. timeout_err is cleared on this transition.
- SELECT (one cycle):
  - Find the lowest enabled index j >= idx.
  - If one exists: cur_eng = j, go to RUN.
  - Otherwise: cur_eng = 3, go to DONE.
- RUN:
  - eng_start[cur_eng] = 1; all other eng_start bits = 0.
  - Watchdog increments every cycle.
  - eng_done[cur_eng] = 1 at an edge -> GAP.
  - Else, watchdog == TIMEOUT_CYCLES-1 -> set timeout_err[cur_eng], go to GAP.
  - eng_done from non-granted engines is ignored.
- GAP (one cycle):
  - eng_start = 0, watchdog cleared, idx = cur_eng+1, go to SELECT.
  - If cur_eng == 2, go directly to DONE.
  - The one-cycle gap guarantees each engine sees start fall before the next engine starts.
- DONE:
  - done = 1, cur_eng = 3, busy = 0.
  - Stays while start = 1. At an edge with start = 0 -> IDLE, and done falls.
- Timing:
  - First eng_start rises 2 edges after the edge that samples start high.
  - Each handoff costs 2 cycles (GAP, SELECT).
  - en_mask = 0: done asserts 2 edges after start is sampled.
- Plot mux (combinational, no added latency):
  - When cur_eng < 3: vga_x = eng_x[cur_eng], vga_y = eng_y[cur_eng], vga_colour = eng_colour[cur_eng].
  - vga_plot = eng_plot[cur_eng] && state == RUN && eng_x[cur_eng] < SCREEN_W && eng_y[cur_eng] < SCREEN_H.
  - Otherwise, all vga outputs = 0.
  - Plots from non-granted engines never reach the adapter. Plots in the completion cycle (the cycle where done is seen) pass through.
- Comparisons are unsigned: x = 8'd160..255 and y = 7'd120..127 are clipped.
- start dropped mid-sequence: ignored; the sequence runs to DONE and then returns to IDLE immediately.
- en_mask changes after latching have no effect until the next run.

Test Plan:
- Reset, then en_mask = 3'b111 with engine models reporting done after 19200 / 500 / 800 cycles.
  - eng_start one-hot order 001 -> 010 -> 100, each separated by one all-zero cycle.
  - done = 1 at cycle 2+19200+500+800+overhead (±1).
  - timeout_err = 0.
- en_mask = 3'b101: eng_start[1] never rises; cur_eng goes 0, 2, 3.
- en_mask = 3'b000: done rises exactly 2 edges after start; eng_start stays 0 throughout.
- Engine 1 never asserts done, TIMEOUT_CYCLES = 64:
  - eng_start[1] falls after 64 cycles and timeout_err = 3'b010.
  - Engine 2 still runs; done = 1.
- Clipping and isolation, with engine 1 granted:
  - Engine 1 plots (159,119): vga_plot = 1. Plots (160,5): vga_plot = 0. Plots (5,120): vga_plot = 0.
  - Engine 0 asserting eng_plot while engine 1 is granted: vga_plot = 0.
- rst_n pulsed low mid-RUN (asynchronous, between edges):
  - All outputs reach their reset values before the next edge.
  - A new start restarts from engine 0.
